// File: rtl/starflux_pkg.sv
// Shared playfield geometry, palette and renderer state encoding
// for the starflux datapath, renderer and VGA top level.
package starflux_pkg;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int SHIP_W = 8;
    localparam int SHIP_H = 4;

    localparam logic [2:0] C_BG    = 3'b000;
    localparam logic [2:0] C_SHOT  = 3'b111;
    localparam logic [2:0] C_USER  = 3'b010;
    localparam logic [2:0] C_ENEMY = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/grid_renderer_pixel_colour.sv
// Combinational colour priority for one playfield pixel:
// enemy ship, then player ship, then bullet bit, then background.
module pixel_colour
    import starflux_pkg::*;
#(
    parameter int         HEIGHT  = starflux_pkg::HEIGHT,
    parameter int         SHIP_W  = starflux_pkg::SHIP_W,
    parameter int         SHIP_H  = starflux_pkg::SHIP_H,
    parameter logic [2:0] C_BG    = starflux_pkg::C_BG,
    parameter logic [2:0] C_SHOT  = starflux_pkg::C_SHOT,
    parameter logic [2:0] C_USER  = starflux_pkg::C_USER,
    parameter logic [2:0] C_ENEMY = starflux_pkg::C_ENEMY
) (
    input  logic [7:0] cx,
    input  logic [6:0] cy,
    input  logic [7:0] user_x,
    input  logic [7:0] enemy_x,
    input  logic       shot,
    output logic [2:0] colour
);

    localparam logic [8:0] SW9     = 9'(SHIP_W);
    localparam logic [6:0] TOP_END = 7'(SHIP_H);
    localparam logic [6:0] BOT_BEG = 7'(HEIGHT - SHIP_H);

    // 9-bit bounds so a ship near the right edge clips instead of wrapping
    logic [8:0] cx9;
    logic [8:0] ux9;
    logic [8:0] ex9;
    logic       in_enemy;
    logic       in_user;

    assign cx9 = {1'b0, cx};
    assign ux9 = {1'b0, user_x};
    assign ex9 = {1'b0, enemy_x};

    assign in_enemy = (cy < TOP_END) && (ex9 <= cx9)
                   && (cx9 < ex9 + SW9);
    assign in_user  = (cy >= BOT_BEG) && (ux9 <= cx9)
                   && (cx9 < ux9 + SW9);

    always_comb begin
        colour = C_BG;
        if (in_enemy) begin
            colour = C_ENEMY;
        end else if (in_user) begin
            colour = C_USER;
        end else if (shot) begin
            colour = C_SHOT;
        end
    end

endmodule

// File: rtl/grid_renderer.sv
// Raster scan-out of the bullet grid and both ships into
// registered (x, y, colour, plot) writes for the VGA adapter.
module grid_renderer
    import starflux_pkg::*;
#(
    parameter int         WIDTH   = starflux_pkg::WIDTH,
    parameter int         HEIGHT  = starflux_pkg::HEIGHT,
    parameter int         SHIP_W  = starflux_pkg::SHIP_W,
    parameter int         SHIP_H  = starflux_pkg::SHIP_H,
    parameter logic [2:0] C_BG    = starflux_pkg::C_BG,
    parameter logic [2:0] C_SHOT  = starflux_pkg::C_SHOT,
    parameter logic [2:0] C_USER  = starflux_pkg::C_USER,
    parameter logic [2:0] C_ENEMY = starflux_pkg::C_ENEMY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                user_x,
    input  logic [7:0]                enemy_x,
    input  logic [WIDTH*HEIGHT-1:0]   grid,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic [2:0]                colour,
    output logic                      plot,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                frame_count
);

    localparam int         IW    = $clog2(WIDTH * HEIGHT);
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [6:0] Y_MAX = 7'(HEIGHT - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    cx;
    logic [6:0]    cy;
    logic [IW-1:0] idx;
    logic [7:0]    ux_q;
    logic [7:0]    ex_q;
    logic          scan_end;
    logic          issue;
    logic [2:0]    pix_colour;

    // scan_end gives DRAW one flush cycle so the last pixel leaves the output stage
    assign issue = (state == DRAW) && !scan_end;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    pixel_colour #(
        .HEIGHT (HEIGHT),
        .SHIP_W (SHIP_W),
        .SHIP_H (SHIP_H),
        .C_BG   (C_BG),
        .C_SHOT (C_SHOT),
        .C_USER (C_USER),
        .C_ENEMY(C_ENEMY)
    ) u_pixel_colour (
        .cx     (cx),
        .cy     (cy),
        .user_x (ux_q),
        .enemy_x(ex_q),
        .shot   (grid[idx]),
        .colour (pix_colour)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = DRAW;
            DRAW: if (scan_end) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            idx         <= '0;
            ux_q        <= '0;
            ex_q        <= '0;
            scan_end    <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                ux_q     <= user_x;
                ex_q     <= enemy_x;
                cx       <= '0;
                cy       <= '0;
                idx      <= '0;
                scan_end <= 1'b0;
            end else if (issue) begin
                idx <= idx + 1'b1;
                if (cx == X_MAX) begin
                    cx <= '0;
                    if (cy == Y_MAX) begin
                        scan_end <= 1'b1;
                    end else begin
                        cy <= cy + 1'b1;
                    end
                end else begin
                    cx <= cx + 1'b1;
                end
            end
            if (state == DONE) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x      <= '0;
            y      <= '0;
            colour <= C_BG;
            plot   <= 1'b0;
        end else begin
            plot <= issue;
            if (issue) begin
                x      <= cx;
                y      <= cy;
                colour <= pix_colour;
            end
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Randomised scoreboard bench for grid_renderer against a
// per-pixel reference of the playfield colour rules.
module tb_grid_renderer;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int NP = W * H;

    typedef struct {
        int         px;
        int         py;
        logic [2:0] c;
    } pix_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    user_x;
    logic [7:0]    enemy_x;
    logic [NP-1:0] grid;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;
    logic          plot;
    logic          busy;
    logic          done;
    logic [7:0]    frame_count;

    pix_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_fc   = 0;

    grid_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .user_x     (user_x),
        .enemy_x    (enemy_x),
        .grid       (grid),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name,
                       input int got, input int want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [2:0] ref_colour(input int px, input int py,
                                              input int ux, input int ex,
                                              input logic shot);
        if (py < 4 && px >= ex && px < ex + 8) return 3'b100;
        if (py >= H - 4 && px >= ux && px < ux + 8) return 3'b010;
        if (shot) return 3'b111;
        return 3'b000;
    endfunction

    // Monitor: every plot must match the next expected raster pixel
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (reset && plot) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_plot", int'({x, y}), 0);
                end else begin
                    e = q.pop_front();
                    chk(x == 8'(e.px) && y == 7'(e.py) && colour == e.c,
                        "pixel", int'({x, y, colour}),
                        (e.px << 10) | (e.py << 3) | int'(e.c));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic run_frame(input int ux, input int ex,
                             input int repulse, input int abort_at);
        @(negedge clk);
        user_x  = 8'(ux);
        enemy_x = 8'(ex);
        start   = 1'b1;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                q.push_back('{xx, yy,
                    ref_colour(xx, yy, ux, ex, grid[yy*W+xx])});
        for (int k = 1; k <= NP + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start   = 1'b0;
                user_x  = 8'($urandom);
                enemy_x = 8'($urandom);
            end
            if (k == repulse) start = 1'b1;
            if (k == repulse + 1) start = 1'b0;
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk(plot == 1'b0, "abort_plot", int'(plot), 0);
                chk(frame_count == 8'd0, "abort_fc", int'(frame_count), 0);
                chk(busy == 1'b0, "abort_busy", int'(busy), 0);
                exp_fc = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk(done == 1'b0, "abort_done", int'(done), 0);
                end
                q.delete();
                reset = 1'b1;
                return;
            end
            chk(busy == (k <= NP + 2), "busy", int'(busy), int'(k <= NP + 2));
            chk(done == (k == NP + 2), "done", int'(done), int'(k == NP + 2));
            if (k == 1) chk(plot == 1'b0, "plot_c1", int'(plot), 0);
            if (k == 2)
                chk(plot && x == 8'd0 && y == 7'd0, "first_plot",
                    int'({plot, x, y}), int'({1'b1, 15'd0}));
            if (k == NP + 1)
                chk(plot && x == 8'd159 && y == 7'd119, "last_plot",
                    int'({plot, x, y}), int'({1'b1, 8'd159, 7'd119}));
            if (k == NP + 2) chk(plot == 1'b0, "plot_after", int'(plot), 0);
            if (k == NP + 3) begin
                exp_fc = (exp_fc + 1) & 255;
                chk(frame_count == 8'(exp_fc), "frame_count",
                    int'(frame_count), exp_fc);
            end
        end
        chk(q.size() == 0, "plots_missing", q.size(), 0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        user_x  = '0;
        enemy_x = '0;
        grid    = '0;
        repeat (3) @(negedge clk);
        chk(x == 0 && y == 0 && colour == 0, "rst_xyc",
            int'({x, y, colour}), 0);
        chk(plot == 0 && busy == 0 && done == 0, "rst_ctl",
            int'({plot, busy, done}), 0);
        chk(frame_count == 0, "rst_fc", int'(frame_count), 0);
        reset = 1'b1;

        repeat (100) begin
            @(negedge clk);
            chk(plot == 0 && busy == 0 && frame_count == 0, "idle",
                int'({plot, busy, frame_count}), 0);
        end

        run_frame(10, 50, 5000, 0);

        grid = '0;
        grid[60*W+80] = 1'b1;
        grid[1*W+52]  = 1'b1;
        grid[118*W+2] = 1'b1;
        for (int i = 0; i < 40; i++) grid[$urandom_range(0, NP-1)] = 1'b1;
        run_frame(156, 50, 0, 0);

        for (int i = 0; i < NP; i++) grid[i] = ($urandom_range(0, 7) == 0);
        run_frame(2, 3, 0, 7000);

        for (int i = 0; i < NP; i++) grid[i] = ($urandom_range(0, 5) == 0);
        run_frame($urandom_range(0, 255), $urandom_range(140, 255), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
